// File: rtl/conv33_pkg.sv
// rtl/conv33_pkg.sv - shared constants, state encoding and helpers for the conv33 engine
package conv33_pkg;

    localparam int CONV_DATA_W = 8;
    localparam int CONV_IMG_H  = 28;
    localparam int CONV_IMG_W  = 28;
    localparam int CONV_PAD    = 1;

    localparam int CONV_PH = CONV_IMG_H + 2 * CONV_PAD;
    localparam int CONV_PW = CONV_IMG_W + 2 * CONV_PAD;
    localparam int CONV_N  = CONV_PH * CONV_PW;

    localparam logic [2:0] ENC_IDLE     = 3'd0;
    localparam logic [2:0] ENC_RUN      = 3'd1;
    localparam logic [2:0] ENC_DRAIN    = 3'd2;
    localparam logic [2:0] ENC_DONE     = 3'd3;
    localparam logic [2:0] ENC_WAIT_LOW = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = ENC_IDLE,
        ST_RUN      = ENC_RUN,
        ST_DRAIN    = ENC_DRAIN,
        ST_DONE     = ENC_DONE,
        ST_WAIT_LOW = ENC_WAIT_LOW
    } state_t;

    // Bit width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv33_pad_scan.sv
// rtl/conv33_pad_scan.sv - padded raster scan counters with interior/last flags and address counters
module conv33_pad_scan
    import conv33_pkg::*;
#(
    parameter int IMG_H  = CONV_IMG_H,
    parameter int IMG_W  = CONV_IMG_W,
    parameter int PAD    = CONV_PAD,
    parameter int SRC_AW = 10,
    parameter int BUF_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              step,
    output logic              interior,
    output logic              last,
    output logic [SRC_AW-1:0] src_addr,
    output logic [BUF_AW-1:0] buf_addr
);

    localparam int PH = IMG_H + 2 * PAD;
    localparam int PW = IMG_W + 2 * PAD;
    localparam int RW = cnt_w(PH + 1);
    localparam int CW = cnt_w(PW + 1);

    localparam logic [RW-1:0] R_LO   = RW'(PAD);
    localparam logic [RW-1:0] R_SPAN = RW'(IMG_H);
    localparam logic [RW-1:0] R_LAST = RW'(PH - 1);
    localparam logic [CW-1:0] C_LO   = CW'(PAD);
    localparam logic [CW-1:0] C_SPAN = CW'(IMG_W);
    localparam logic [CW-1:0] C_LAST = CW'(PW - 1);

    logic [RW-1:0]     pr_q, pr_d, pr_off;
    logic [CW-1:0]     pc_q, pc_d, pc_off;
    logic [SRC_AW-1:0] src_q, src_d;
    logic [BUF_AW-1:0] buf_q, buf_d;

    always_comb begin
        // Offsets below the border wrap to large values, so one unsigned compare covers both edges.
        pr_off   = pr_q - R_LO;
        pc_off   = pc_q - C_LO;
        interior = (pr_off < R_SPAN) && (pc_off < C_SPAN);
        last     = (pr_q == R_LAST) && (pc_q == C_LAST);

        pr_d  = pr_q;
        pc_d  = pc_q;
        src_d = src_q;
        buf_d = buf_q;
        if (clear) begin
            pr_d  = '0;
            pc_d  = '0;
            src_d = '0;
            buf_d = '0;
        end else if (step) begin
            buf_d = buf_q + BUF_AW'(1);
            if (interior) begin
                src_d = src_q + SRC_AW'(1);
            end
            if (pc_q == C_LAST) begin
                pc_d = '0;
                pr_d = pr_q + RW'(1);
            end else begin
                pc_d = pc_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr_q  <= '0;
            pc_q  <= '0;
            src_q <= '0;
            buf_q <= '0;
        end else begin
            pr_q  <= pr_d;
            pc_q  <= pc_d;
            src_q <= src_d;
            buf_q <= buf_d;
        end
    end

    assign src_addr = src_q;
    assign buf_addr = buf_q;

endmodule

// File: rtl/conv33_input_load.sv
// rtl/conv33_input_load.sv - conv33 input-load stage: padded feature-map copy into the window buffer
module conv33_input_load
    import conv33_pkg::*;
#(
    parameter int DATA_W = CONV_DATA_W,
    parameter int IMG_H  = CONV_IMG_H,
    parameter int IMG_W  = CONV_IMG_W,
    parameter int PAD    = CONV_PAD,
    parameter int SRC_AW = 10,
    parameter int BUF_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              input_start,
    output logic              input_done,
    output logic              busy,
    output logic              src_en,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic              buf_we,
    output logic [BUF_AW-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_wdata
);

    state_t            state_q, state_d;
    logic              wr_we_q, wr_we_d;
    logic              wr_int_q, wr_int_d;
    logic [BUF_AW-1:0] wr_addr_q, wr_addr_d;

    logic              scan_clear;
    logic              scan_step;
    logic              scan_interior;
    logic              scan_last;
    logic [SRC_AW-1:0] scan_src;
    logic [BUF_AW-1:0] scan_buf;

    conv33_pad_scan #(
        .IMG_H  (IMG_H),
        .IMG_W  (IMG_W),
        .PAD    (PAD),
        .SRC_AW (SRC_AW),
        .BUF_AW (BUF_AW)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .clear    (scan_clear),
        .step     (scan_step),
        .interior (scan_interior),
        .last     (scan_last),
        .src_addr (scan_src),
        .buf_addr (scan_buf)
    );

    always_comb begin
        state_d    = state_q;
        scan_clear = 1'b0;
        scan_step  = (state_q == ST_RUN);
        // Issue stage hands its position to the write stage one cycle later, matching BRAM latency.
        wr_we_d    = scan_step;
        wr_int_d   = scan_step && scan_interior;
        wr_addr_d  = scan_step ? scan_buf : '0;

        case (state_q)
            ST_IDLE: begin
                if (input_start) begin
                    state_d    = ST_RUN;
                    scan_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (scan_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN:    state_d = ST_DONE;
            ST_DONE:     state_d = input_start ? ST_WAIT_LOW : ST_IDLE;
            ST_WAIT_LOW: begin
                if (!input_start) begin
                    state_d = ST_IDLE;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_we_q   <= 1'b0;
            wr_int_q  <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_we_q   <= wr_we_d;
            wr_int_q  <= wr_int_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign src_en     = scan_step && scan_interior;
    assign src_addr   = scan_src;
    assign buf_we     = wr_we_q;
    assign buf_addr   = wr_addr_q;
    assign buf_wdata  = (wr_we_q && wr_int_q) ? src_data : '0;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_DONE);
    assign input_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv33_input_load.sv
// tb/tb_conv33_input_load.sv - scoreboard bench for conv33_input_load over three geometries
module tb_conv33_input_load;

    typedef struct {
        int k;
        int addr;
        int data;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start, done, busy, src_en, buf_we;
    logic [9:0] src_addr [3];
    logic [9:0] buf_addr [3];
    logic [7:0] src_data [3];
    logic [7:0] buf_wdata [3];

    logic [7:0] mem [0:1023];
    logic [7:0] shadow [0:31];
    ent_t       wr_q [$];
    ent_t       rd_q [$];
    ent_t       e;
    int         checks = 0;
    int         failures = 0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         last_src = -1;
    int         last_buf = -1;
    logic [9:0] prev_src1 = '0;
    logic       prev_en1 = 1'b0;

    always #5 clk = ~clk;

    conv33_input_load #(.DATA_W(8), .IMG_H(3), .IMG_W(4), .PAD(1), .SRC_AW(10), .BUF_AW(10)) u_dut0 (
        .clk(clk), .rst(rst), .input_start(start[0]), .input_done(done[0]), .busy(busy[0]),
        .src_en(src_en[0]), .src_addr(src_addr[0]), .src_data(src_data[0]),
        .buf_we(buf_we[0]), .buf_addr(buf_addr[0]), .buf_wdata(buf_wdata[0]));

    conv33_input_load #(.DATA_W(8), .IMG_H(2), .IMG_W(2), .PAD(0), .SRC_AW(10), .BUF_AW(10)) u_dut1 (
        .clk(clk), .rst(rst), .input_start(start[1]), .input_done(done[1]), .busy(busy[1]),
        .src_en(src_en[1]), .src_addr(src_addr[1]), .src_data(src_data[1]),
        .buf_we(buf_we[1]), .buf_addr(buf_addr[1]), .buf_wdata(buf_wdata[1]));

    conv33_input_load #(.DATA_W(8), .IMG_H(28), .IMG_W(28), .PAD(1), .SRC_AW(10), .BUF_AW(10)) u_dut2 (
        .clk(clk), .rst(rst), .input_start(start[2]), .input_done(done[2]), .busy(busy[2]),
        .src_en(src_en[2]), .src_addr(src_addr[2]), .src_data(src_data[2]),
        .buf_we(buf_we[2]), .buf_addr(buf_addr[2]), .buf_wdata(buf_wdata[2]));

    // Source BRAM model: one-cycle read latency.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (src_en[k]) src_data[k] <= mem[src_addr[k]];
        end
    end

    function automatic int cfg_h(int k);
        case (k)
            0: return 3;
            1: return 2;
            default: return 28;
        endcase
    endfunction

    function automatic int cfg_w(int k);
        case (k)
            0: return 4;
            1: return 2;
            default: return 28;
        endcase
    endfunction

    function automatic int cfg_p(int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int out_or(int k);
        return int'(done[k] | busy[k] | src_en[k] | buf_we[k] |
                    (|src_addr[k]) | (|buf_addr[k]) | (|buf_wdata[k]));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every read and write the DUTs present is matched against the scoreboard.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (src_en[k]) begin
                rd_cnt++;
                last_src = int'(src_addr[k]);
                if (rd_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    e = rd_q.pop_front();
                    check("rd_inst", k, e.k);
                    check("src_addr", int'(src_addr[k]), e.addr);
                end
            end
            if (buf_we[k]) begin
                wr_cnt++;
                last_buf = int'(buf_addr[k]);
                if (k == 0) shadow[buf_addr[0][4:0]] = buf_wdata[0];
                if (k == 1) check("pad0_delay", int'(buf_addr[1]), prev_en1 ? int'(prev_src1) : -1);
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_inst", k, e.k);
                    check("buf_addr", int'(buf_addr[k]), e.addr);
                    check("buf_wdata", int'(buf_wdata[k]), e.data);
                end
            end
        end
        prev_src1 = src_addr[1];
        prev_en1  = src_en[1];
    end

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 1024; i++) mem[i] = rnd ? 8'($urandom) : 8'(i + 1);
    endtask

    // Reference: walk the padded image by row/column and decide each pixel from the geometry.
    task automatic push_model(input int k);
        int h, w, p, pw, idx;
        bit ins;
        h  = cfg_h(k);
        w  = cfg_w(k);
        p  = cfg_p(k);
        pw = w + 2 * p;
        for (int r = 0; r < h + 2 * p; r++) begin
            for (int c = 0; c < pw; c++) begin
                ins = (r >= p) && (r < p + h) && (c >= p) && (c < p + w);
                if (ins) begin
                    idx = (r - p) * w + (c - p);
                    wr_q.push_back('{k, r * pw + c, int'(mem[idx])});
                    rd_q.push_back('{k, idx, 0});
                end else begin
                    wr_q.push_back('{k, r * pw + c, 0});
                end
            end
        end
    endtask

    task automatic do_run(input int k, input int hold);
        int h, w, p, n, cyc, bad, busy_cnt;
        bit got;
        h  = cfg_h(k);
        w  = cfg_w(k);
        p  = cfg_p(k);
        n  = (h + 2 * p) * (w + 2 * p);
        wr_cnt = 0;
        rd_cnt = 0;
        push_model(k);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        start[k] = 1'b1;
        cyc = 0;
        got = 1'b0;
        busy_cnt = 0;
        while (!got && cyc < n + 20) begin
            @(negedge clk);
            cyc++;
            busy_cnt += int'(busy[k]);
            if (done[k]) got = 1'b1;
        end
        check("done_latency", got ? cyc : -1, n + 2);
        check("busy_cycles", busy_cnt, n + 2);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bad += int'(busy[k]) + int'(done[k]) + int'(src_en[k]) + int'(buf_we[k]);
        end
        start[k] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            bad += int'(busy[k]) + int'(done[k]) + int'(src_en[k]) + int'(buf_we[k]);
        end
        check("quiet_after_done", bad, 0);
        check("wr_count", wr_cnt, n);
        check("rd_count", rd_cnt, h * w);
        check("wr_q_empty", wr_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);
    endtask

    task automatic buf_contents_check();
        int r, c, exp;
        for (int a = 0; a < 30; a++) begin
            r = a / 6;
            c = a % 6;
            exp = (r >= 1 && r <= 3 && c >= 1 && c <= 4) ? (r - 1) * 4 + c : 0;
            check("buf_content", int'(shadow[a]), exp);
        end
    endtask

    task automatic reset_abort_test();
        int bad;
        fill_mem(1'b1);
        push_model(0);
        start[0] = 1'b1;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_outputs_zero", out_or(0), 0);
        start[0] = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            bad += out_or(0);
        end
        check("rst_no_done", bad, 0);
        rst = 1'b0;
        wr_q.delete();
        rd_q.delete();
        @(negedge clk);
        check("post_rst_idle", out_or(0), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check("reset_outputs", out_or(k), 0);
        rst = 1'b0;
        @(negedge clk);

        fill_mem(1'b0);
        for (int i = 0; i < 32; i++) shadow[i] = 8'hee;
        do_run(0, 5);
        buf_contents_check();
        for (int i = 0; i < 32; i++) shadow[i] = 8'hee;
        do_run(0, 5);
        buf_contents_check();

        fill_mem(1'b1);
        do_run(1, $urandom_range(0, 3));

        reset_abort_test();
        fill_mem(1'b1);
        do_run(0, 2);

        fill_mem(1'b1);
        do_run(2, 1);
        check("last_src_addr", last_src, 783);
        check("last_buf_addr", last_buf, 899);

        for (int i = 0; i < 4; i++) begin
            fill_mem(1'b1);
            do_run($urandom_range(0, 1), $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv33_input_load.md
Name: conv33_input_load

Overview:
- Input-load stage of the conv33 engine. Driven by the conv33 controller through input_start / input_done.
- On start, scans one zero-padded feature map in raster order. Reads interior pixels from the source feature-map BRAM and writes the full padded image into the conv33 window buffer, where the compute stage consumes it.
- Padding pixels are generated as zero and are never read from memory.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_H, 28, unpadded image rows.
- IMG_W, 28, unpadded image columns.
- PAD, 1, zero border width on each side (0..2).
- SRC_AW, 10, source BRAM address width; must be at least clog2(IMG_H*IMG_W).
- BUF_AW, 10, window buffer address width; must be at least clog2((IMG_H+2*PAD)*(IMG_W+2*PAD)).

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- input_start, input, 1, level request from the controller; held high until input_done is seen.
- input_done, output, 1, one-cycle completion pulse.
- busy, output, 1, high from the first issue cycle through the done cycle.
- src_en, output, 1, source BRAM read enable.
- src_addr, output, SRC_AW, source read address, row-major (r*IMG_W + c).
- src_data, input, DATA_W, source read data; valid exactly 1 cycle after src_en.
- buf_we, output, 1, window buffer write enable.
- buf_addr, output, BUF_AW, window buffer address, padded row-major.
- buf_wdata, output, DATA_W, window buffer write data.

Behaviour:
- Clocking: single clock clk. rst is asynchronous and active-high. rst clears all state and drives every output to 0; the state machine returns to IDLE.
- Geometry: PH = IMG_H+2*PAD, PW = IMG_W+2*PAD, N = PH*PW. Scan counters pr in 0..PH-1 and pc in 0..PW-1.
- Interior test: PAD <= pr < PAD+IMG_H and PAD <= pc < PAD+IMG_W.
- States:
  - IDLE: wait for a start request.
  - RUN: one issue per cycle.
  - DRAIN: last write completes.
  - DONE: completion pulse.
  - WAIT_LOW: wait for the request to drop.
- IDLE -> RUN: input_start sampled high. Counters and src_addr are cleared on this edge.
- RUN, each cycle (issue stage):
  - src_en = interior; src_addr = current source counter.
  - The source counter increments after each interior issue. Addresses are produced by counters only, with no multiplier.
  - The issue stage forwards the interior flag and the padded address into a 1-deep pipeline register.
- Write stage (the cycle after an issue):
  - buf_we = 1.
  - buf_addr = pr*PW + pc of that issue, also produced by an incrementing counter.
  - buf_wdata = src_data if the forwarded flag is set, else 0.
- RUN -> DRAIN after issue index N-1, i.e. pr=PH-1 and pc=PW-1. DRAIN carries the final write and issues no read.
- DRAIN -> DONE.
- DONE:
  - input_done = 1 for exactly one cycle.
  - Next state is IDLE if input_start is low, otherwise WAIT_LOW.
- WAIT_LOW -> IDLE when input_start is low. This blocks re-triggering from the held level.
- Latency: N issue cycles + 1 drain cycle. input_done is asserted in cycle N+2 after the edge that sampled start. Exactly N buf writes and IMG_H*IMG_W src reads occur per run.
- Column wrap: at pc=PW-1, pc <= 0 and pr increments.
- PAD=0: every position is interior, and buf_addr equals src_addr delayed by one cycle.
- input_start dropping during RUN or DRAIN is ignored; the run completes and pulses done.
- Reset mid-run: the run aborts immediately and no done pulse is produced. Window buffer contents are then undefined, and the controller restarts from IDLE.
- src_data is only sampled in a write cycle that follows an interior issue.

Decomposition:
- Shared package conv33_pkg:
  - DATA_W and the default image dimensions.
  - Derived constants PH, PW and N.
  - State encoding localparams for this block.
- One sub-module is natural: conv33_pad_scan. It holds the pr/pc counters, the interior flag, the last-position flag and the two address counters. The top level keeps the FSM and the 1-stage write pipeline.

Test Plan:
- IMG_H=3, IMG_W=4, PAD=1, source holding pixel value = address+1, input_start held until done -> 30 buf writes, 12 src reads, and input_done exactly 32 cycles after start sampled.
- Same configuration, buffer contents after the run -> addresses 0..5, 6, 11, 12, 17, 18, 23, 24..29 hold 0. buf[7..10] = 1..4, buf[13..16] = 5..8, buf[19..22] = 9..12.
- PAD=0 with IMG 2x2 -> 4 writes; buf_addr 0..3 each one cycle after src_addr 0..3; input_done 6 cycles after start.
- input_start held high 5 cycles past input_done -> state stays in WAIT_LOW, no second run, and a new start after it drops produces a second identical run.
- rst asserted at issue cycle 10 -> all outputs 0 immediately and no input_done. A later start runs the full 30 writes from buf_addr 0.
- Default configuration 28x28, PAD=1 -> 900 writes, 784 reads, last src_addr 783, last buf_addr 899, input_done after 902 cycles.
